// File: rtl/pipe_mux_nway_if.sv
// pipe_mux_nway_if: N-way input bus plus registered output handshake for pipe_mux_nway.
interface pipe_mux_nway_if #(
    parameter int WIDTH = 32,
    parameter int WAYS  = 4,
    parameter int SELW  = 2
);
    logic [WAYS*WIDTH-1:0] in_data;
    logic [WAYS-1:0]       in_valid;
    logic [WAYS-1:0]       in_ready;
    logic [SELW-1:0]       sel;
    logic                  mode;
    logic [WIDTH-1:0]      out_data;
    logic [SELW-1:0]       out_src;
    logic                  out_valid;
    logic                  out_ready;

    modport master (
        output in_data, in_valid, sel, mode, out_ready,
        input  in_ready, out_data, out_src, out_valid
    );

    modport slave (
        input  in_data, in_valid, sel, mode, out_ready,
        output in_ready, out_data, out_src, out_valid
    );
endinterface

// File: rtl/pipe_mux_nway.sv
// pipe_mux_nway: N-way mux into one output register, direct-select or round-robin arbitration.
module pipe_mux_nway #(
    parameter int WIDTH = 32,
    parameter int WAYS  = 4,
    parameter int SELW  = 2
) (
    input logic clk,
    input logic reset,
    pipe_mux_nway_if.slave bus
);
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SELW-1:0]  out_src_q, out_src_d, rr_ptr_q, rr_ptr_d, grant;
    logic             out_valid_q, can_load, found, xfer;
    logic [WAYS-1:0]  ready;
    logic [SELW:0]    idx;

    assign can_load = !out_valid_q || bus.out_ready;

    // Scan downward so the way nearest rr_ptr (lowest offset) is the last writer and wins.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            idx = {1'b0, rr_ptr_q} + (SELW+1)'(i);
            idx = (idx >= (SELW+1)'(WAYS)) ? idx - (SELW+1)'(WAYS) : idx;
            if (bus.in_valid[idx[SELW-1:0]]) begin
                grant = idx[SELW-1:0];
                found = 1'b1;
            end
        end
    end

    // Direct mode ignores in_valid so producers may wait on in_ready before asserting valid.
    always_comb begin
        ready = '0;
        if (!reset && can_load) begin
            if (!bus.mode && ({1'b0, bus.sel} < (SELW+1)'(WAYS)))
                ready[bus.sel] = 1'b1;
            else if (bus.mode && found)
                ready[grant] = 1'b1;
        end
    end

    assign bus.in_ready = ready;

    always_comb begin
        xfer = 1'b0;
        out_data_d = out_data_q;
        out_src_d = out_src_q;
        for (int k = 0; k < WAYS; k++) begin
            if (ready[k] && bus.in_valid[k]) begin
                xfer = 1'b1;
                out_data_d = bus.in_data[k*WIDTH +: WIDTH];
                out_src_d = SELW'(k);
            end
        end
        rr_ptr_d = rr_ptr_q;
        if (xfer && bus.mode)
            rr_ptr_d = (out_src_d == SELW'(WAYS - 1)) ? '0 : out_src_d + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q <= '0;
            out_src_q <= '0;
            rr_ptr_q <= '0;
        end else if (can_load) begin
            out_valid_q <= xfer;
            out_data_q <= out_data_d;
            out_src_q <= out_src_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign bus.out_data = out_data_q;
    assign bus.out_src = out_src_q;
    assign bus.out_valid = out_valid_q;
endmodule

// File: doc/pipe_mux_nway.md
PIPE_MUX_NWAY -- requirements
Module: pipe_mux_nway

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the data width of each input way and of the output.
REQ-002 The block SHALL have parameter WAYS, default 4, giving the number of input ways; legal range is 2..16.
REQ-003 The block SHALL have parameter SELW, default 2, giving the select and source-index width; SELW SHALL equal ceil(log2(WAYS)).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port in_data, input, WAYS*WIDTH bits: way k occupies bits [k*WIDTH+WIDTH-1 : k*WIDTH].
REQ-007 The block SHALL have port in_valid, input, WAYS bits: bit k set means way k presents data.
REQ-008 The block SHALL have port in_ready, output, WAYS bits: bit k set means way k transfers this cycle if its valid bit is set.
REQ-009 The block SHALL have port sel, input, SELW bits: the way index used in direct mode.
REQ-010 The block SHALL have port mode, input, 1 bit: 0 selects direct mode, 1 selects round-robin mode.
REQ-011 The block SHALL have port out_data, output, WIDTH bits: registered output data.
REQ-012 The block SHALL have port out_src, output, SELW bits: index of the way that supplied out_data.
REQ-013 The block SHALL have port out_valid, output, 1 bit: out_data and out_src are valid.
REQ-014 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the output this cycle.

Function
REQ-015 The block SHALL contain one output register stage holding out_data, out_src and out_valid.
REQ-016 The stage SHALL be loadable in a cycle (can_load) when out_valid=0, or when out_valid=1 and out_ready=1.
REQ-017 Direct mode, sel<WAYS: in_ready[sel] SHALL equal can_load and all other in_ready bits SHALL be 0.
REQ-018 Direct mode, sel>=WAYS: all in_ready bits SHALL be 0 and no transfer SHALL occur.
REQ-019 Round-robin mode: grant SHALL go to the first way k with in_valid[k]=1, searching from rr_ptr upward and wrapping modulo WAYS; in_ready[grant] SHALL equal can_load and all other bits SHALL be 0.
REQ-020 Round-robin mode with no in_valid bit set: all in_ready bits SHALL be 0.
REQ-021 A transfer SHALL occur when in_valid[k] and in_ready[k] are both 1; on the next edge the stage SHALL load out_data = way k data, out_src = k and out_valid = 1.
REQ-022 Latency from transfer to out_valid SHALL be exactly 1 cycle, and sustained throughput SHALL be 1 transfer per cycle when out_ready is held at 1.
REQ-023 When can_load=1 and no transfer occurs, out_valid SHALL go to 0 on the next edge.
REQ-024 While out_valid=1 and out_ready=0, out_data and out_src SHALL hold stable and all in_ready bits SHALL be 0.
REQ-025 rr_ptr is an internal SELW-bit register; on each round-robin transfer from way k it SHALL update to (k+1) mod WAYS, and otherwise it SHALL hold.
REQ-026 A mode or sel change SHALL affect only the current cycle's in_ready and grant, and SHALL NOT alter a held output.
REQ-027 in_ready SHALL be combinational from in_valid, sel, mode, rr_ptr, out_valid and out_ready only; there SHALL be no path from in_data.
REQ-028 in_ready SHALL NOT depend combinationally on in_valid in direct mode.

Reset
REQ-029 With reset=1 at a rising edge, out_valid, out_data, out_src and rr_ptr SHALL all become 0, regardless of any in-flight or held output.
REQ-030 While reset=1, all in_ready bits SHALL be 0.
REQ-031 Normal operation SHALL resume on the first edge after reset returns to 0.

Verification
REQ-032 The bench SHALL cover direct-mode streaming: WAYS=4, WIDTH=32, mode=0, out_ready=1, way k data = k+100, sel stepping 0..3 one per cycle -> out_data 100,101,102,103 and out_src 0..3 on consecutive cycles, each 1 cycle after its transfer.
REQ-033 The bench SHALL cover backpressure: a held output with data 0x55, then out_ready=0 for 3 cycles -> out_data holds 0x55, in_ready=0000, no loss; out_ready=1 -> the next word appears on the following cycle.
REQ-034 The bench SHALL cover round-robin fairness: mode=1, in_valid=1111 held, out_ready=1 -> out_src sequence 0,1,2,3,0; then in_valid=1010 -> grants alternate 1,3.
REQ-035 The bench SHALL cover wrap-around: rr_ptr=3, in_valid=0001 -> grant to way 0 and rr_ptr becomes 1.
REQ-036 The bench SHALL cover an illegal select: WAYS=3, sel=3, mode=0 -> in_ready=000 and out_valid falls to 0 after the pending output drains.
REQ-037 The bench SHALL cover reset mid-operation: reset=1 while out_valid=1 and out_ready=0 -> next cycle out_valid=0, out_data=0, out_src=0, and the next round-robin grant starts at way 0.
